// File: rtl/issue_scheduler_pkg.sv
// Shared uop class codes, queue payload layout and multiplier FSM states for the issue stage.
package issue_scheduler_pkg;

  localparam int REG_W = 4;
  localparam int NSRC  = 3;

  typedef enum logic [3:0] {
    UOP_NONE      = 4'd0,
    UOP_INTEGER   = 4'd1,
    UOP_INTEGER_M = 4'd2,
    UOP_LOAD      = 4'd3,
    UOP_STORE     = 4'd4,
    UOP_BRANCH    = 4'd5
  } uop_class_e;

  // 24-bit queue payload {class, dest, wr, src{c,b,a}, src_use{c,b,a}}
  typedef struct packed {
    logic [3:0]            cls;
    logic [REG_W-1:0]      dest;
    logic                  wr;
    logic [NSRC*REG_W-1:0] src;
    logic [NSRC-1:0]       src_use;
  } uop_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/issue_scheduler_uop_fifo.sv
// In-order uop queue with push/pop/flush and an occupancy count; head reads as zero when empty.
module issue_scheduler_uop_fifo
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  uop_t                       push_data,
  output uop_t                       head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  uop_t           mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue stage: uop queue, register scoreboard, hazard checks and a shared multiplier occupancy FSM.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NREGS   = 16,
  parameter int MUL_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_class,
  input  logic [3:0]                 in_dest,
  input  logic                       in_wr,
  input  logic [11:0]                in_src,
  input  logic [2:0]                 in_src_use,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [3:0]                 iss_class,
  output logic [3:0]                 iss_dest,
  output logic                       iss_wr,
  input  logic                       wb_valid,
  input  logic [3:0]                 wb_dest,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [NREGS-1:0]           sb_pending,
  output logic                       mul_busy
);

  localparam int QW = $clog2(DEPTH+1);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [QW-1:0] Q_FULL = QW'(DEPTH);

  uop_t             in_uop;
  uop_t             head;
  logic             empty;
  logic             raw;
  logic             waw;
  logic             fire;
  logic             push;
  logic             head_is_mul;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  mul_state_e       mul_state;
  logic [CW-1:0]    mul_cnt;

  assign in_uop = '{cls: in_class, dest: in_dest, wr: in_wr, src: in_src, src_use: in_src_use};

  assign in_ready = !rst && !flush && (q_count != Q_FULL);
  assign push     = in_valid && in_ready && (in_class != 4'(UOP_NONE));

  issue_scheduler_uop_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (fire),
    .flush     (flush),
    .push_data (in_uop),
    .head      (head),
    .count     (q_count)
  );

  assign empty       = (q_count == '0);
  assign head_is_mul = (head.cls == 4'(UOP_INTEGER_M));

  // Hazards look only at the registered scoreboard; a same-cycle writeback does not unblock.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (head.src_use[i] && sb_pending[head.src[i*REG_W +: REG_W]]) raw = 1'b1;
    end
  end

  assign waw       = head.wr && sb_pending[head.dest];
  assign iss_valid = !empty && !flush && !raw && !waw && !(head_is_mul && mul_busy);
  assign fire      = iss_valid && iss_ready;

  assign iss_class = head.cls;
  assign iss_dest  = head.dest;
  assign iss_wr    = head.wr;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (fire && head.wr) set_mask[head.dest] = 1'b1;
    if (wb_valid)        clr_mask[wb_dest]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_pending <= '0;
    else     sb_pending <= (sb_pending & ~clr_mask) | set_mask;
  end

  // Multiplier occupancy: counter loads MUL_LAT-1 on issue and drops back to idle on reaching 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state <= M_IDLE;
      mul_cnt   <= '0;
    end else begin
      case (mul_state)
        M_IDLE: begin
          if (fire && head_is_mul && (MUL_LAT > 1)) begin
            mul_state <= M_BUSY;
            mul_cnt   <= CW'(MUL_LAT - 1);
          end
        end
        M_BUSY: begin
          mul_cnt <= mul_cnt - 1'b1;
          if (mul_cnt == CW'(1)) mul_state <= M_IDLE;
        end
        default: mul_state <= M_IDLE;
      endcase
    end
  end

  assign mul_busy = (mul_state == M_BUSY);

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: hand-written cycle table for the directed scenarios plus random traffic vs a queue model.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int DEPTH = 4, NREGS = 16, MUL_LAT = 3;
  localparam int QW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, in_ready, in_wr, iss_valid, iss_ready, iss_wr;
  logic             wb_valid, mul_busy;
  logic [3:0]       in_class, in_dest, iss_class, iss_dest, wb_dest;
  logic [11:0]      in_src;
  logic [2:0]       in_src_use;
  logic [QW-1:0]    q_count;
  logic [NREGS-1:0] sb_pending;

  issue_scheduler #(.DEPTH(DEPTH), .NREGS(NREGS), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_dest(in_dest), .in_wr(in_wr), .in_src(in_src),
    .in_src_use(in_src_use), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_class(iss_class), .iss_dest(iss_dest), .iss_wr(iss_wr), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .q_count(q_count), .sb_pending(sb_pending), .mul_busy(mul_busy)
  );

  typedef struct {
    bit rst, fl, iv; logic [3:0] cls, dst; bit wr; logic [11:0] src; logic [2:0] su;
    bit ir, wbv; logic [3:0] wbd;
    bit e_inr, e_iv; int e_qc; logic [15:0] e_sb; bit e_mb;
  } vec_t;

  vec_t tab[$];
  int total = 0;
  int bad = 0;

  // Reference model: plain queue of uops, pending-register bit array, remaining multiplier busy cycles.
  uop_t             mq[$];
  logic [NREGS-1:0] msb;
  int               mrem;

  function automatic vec_t row(bit r, bit fl, bit iv, int cls, int dst, bit wr, int src, int su,
                               bit ir, bit wbv, int wbd, bit einr, bit eiv, int eqc, int esb, bit emb);
    vec_t v;
    v.rst = r; v.fl = fl; v.iv = iv; v.cls = 4'(cls); v.dst = 4'(dst); v.wr = wr;
    v.src = 12'(src); v.su = 3'(su); v.ir = ir; v.wbv = wbv; v.wbd = 4'(wbd);
    v.e_inr = einr; v.e_iv = eiv; v.e_qc = eqc; v.e_sb = 16'(esb); v.e_mb = emb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.fl; in_valid = v.iv; in_class = v.cls; in_dest = v.dst;
    in_wr = v.wr; in_src = v.src; in_src_use = v.su; iss_ready = v.ir;
    wb_valid = v.wbv; wb_dest = v.wbd;
  endtask

  function automatic bit m_hazard(input uop_t u);
    for (int i = 0; i < 3; i++)
      if (u.src_use[i] && msb[u.src[i*4 +: 4]]) return 1'b1;
    return u.wr && msb[u.dest];
  endfunction

  task automatic step(input bit use_tab, input vec_t v, input int idx);
    uop_t h, nu;
    bit e_ir, e_iv, fire;
    int n;
    #2;
    n = mq.size();
    h = (n > 0) ? mq[0] : '0;
    e_ir = !rst && !flush && (n < DEPTH);
    e_iv = (n > 0) && !flush && !m_hazard(h) && !(h.cls == 4'(UOP_INTEGER_M) && mrem > 0);
    chk($sformatf("c%0d in_ready", idx), 32'(in_ready), 32'(e_ir));
    chk($sformatf("c%0d iss_valid", idx), 32'(iss_valid), 32'(e_iv));
    chk($sformatf("c%0d iss_head", idx), {23'd0, iss_class, iss_dest, iss_wr},
        {23'd0, h.cls, h.dest, h.wr});
    chk($sformatf("c%0d q_count", idx), 32'(q_count), 32'(n));
    chk($sformatf("c%0d sb_pending", idx), 32'(sb_pending), 32'(msb));
    chk($sformatf("c%0d mul_busy", idx), 32'(mul_busy), 32'(mrem > 0));
    if (use_tab) begin
      chk($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(v.e_inr));
      chk($sformatf("row%0d iss_valid", idx), 32'(iss_valid), 32'(v.e_iv));
      chk($sformatf("row%0d q_count", idx), 32'(q_count), 32'(v.e_qc));
      chk($sformatf("row%0d sb_pending", idx), 32'(sb_pending), 32'(v.e_sb));
      chk($sformatf("row%0d mul_busy", idx), 32'(mul_busy), 32'(v.e_mb));
    end
    fire = e_iv && iss_ready;
    nu = '{cls: in_class, dest: in_dest, wr: in_wr, src: in_src, src_use: in_src_use};
    @(posedge clk);
    if (rst) begin
      mq.delete(); msb = '0; mrem = 0;
    end else begin
      if (wb_valid) msb[wb_dest] = 1'b0;
      if (fire && h.wr) msb[h.dest] = 1'b1;
      if (fire && h.cls == 4'(UOP_INTEGER_M)) mrem = MUL_LAT - 1;
      else if (mrem > 0) mrem--;
      if (flush) mq.delete();
      else begin
        if (fire) void'(mq.pop_front());
        if (in_valid && e_ir && in_class != 4'd0) mq.push_back(nu);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int pend[$];
    msb = '0; mrem = 0;
    //             rst fl iv cls dst wr src  su ir wbv wbd | inr iv qc sb    mb
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 'h0,  0));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 1, 1, 0,    0, 1, 0, 0,   1, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 2, 1, 0,    0, 1, 0, 0,   1, 1, 1, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 3, 1, 0,    0, 1, 0, 0,   1, 1, 1, 'h2,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 1, 1, 'h6,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 0, 0, 'hE,  0));
    tab.push_back(row(0, 0, 1, 1, 4, 1, 0,    0, 1, 0, 0,   1, 0, 0, 'hE,  0));
    tab.push_back(row(0, 0, 1, 1, 6, 1, 'h4,  1, 1, 0, 0,   1, 1, 1, 'hE,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 0, 1, 'h1E, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 1, 4,   1, 0, 1, 'h1E, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 1, 1, 'hE,  0));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 'h4E, 0));
    tab.push_back(row(0, 0, 1, 2, 1, 1, 0,    0, 1, 0, 0,   1, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 2, 2, 1, 0,    0, 1, 0, 0,   1, 1, 1, 'h0,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 0, 1, 'h2,  1));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 0, 1, 'h2,  1));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 1, 1, 'h2,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,   1, 0, 0, 'h6,  1));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 'h6,  1));
    tab.push_back(row(0, 0, 1, 1, 5, 1, 0,    0, 0, 0, 0,   1, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0,   1, 1, 1, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0,   1, 1, 2, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0,   1, 1, 3, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0,   0, 1, 4, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 0, 0, 0,    0, 1, 0, 0,   0, 1, 4, 'h0,  0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   1, 1, 3, 'h20, 0));
    tab.push_back(row(0, 1, 1, 1, 0, 0, 0,    0, 1, 0, 0,   0, 0, 3, 'h20, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5,   1, 0, 0, 'h20, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   1, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 2, 7, 1, 0,    0, 0, 0, 0,   1, 0, 0, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 8, 0, 0,    0, 1, 0, 0,   1, 1, 1, 'h0,  0));
    tab.push_back(row(0, 0, 1, 1, 9, 0, 0,    0, 0, 0, 0,   1, 1, 1, 'h80, 1));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 1, 2, 'h80, 1));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,   1, 0, 0, 'h0,  0));

    drive(tab[0]);
    @(negedge clk);
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i]);
      step(1'b1, tab[i], i);
    end

    // Randomized traffic; writebacks only target registers the model holds pending.
    for (int c = 0; c < 3000; c++) begin
      v = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(0, 199) == 0);
      v.fl  = ($urandom_range(0, 29) == 0);
      v.iv  = ($urandom_range(0, 9) < 7);
      v.cls = ($urandom_range(0, 2) == 0) ? 4'(UOP_INTEGER_M) : 4'($urandom_range(0, 5));
      v.dst = 4'($urandom_range(0, 15));
      v.wr  = 1'($urandom_range(0, 1));
      v.src = 12'($urandom);
      v.su  = 3'($urandom);
      v.ir  = ($urandom_range(0, 9) < 7);
      pend.delete();
      for (int r = 0; r < NREGS; r++) if (msb[r]) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
        v.wbv = 1'b1;
        v.wbd = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      end
      drive(v);
      step(1'b0, v, 1000 + c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
